// File: rtl/lab1_imul_mac_pkg.sv
// lab1_imul_mac_pkg: shared types and constants for the multiply-accumulate
// client.
//   state_t  - client FSM encoding (IDLE, ISSUE, WAIT, DONE). It is
//              package-scoped so it cannot clash with other global state
//              typedefs.
//   SAT_POS  - signed saturation limits for the default 32-bit datapath.
//   SAT_NEG
package lab1_imul_mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [31:0] SAT_POS = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_NEG = 32'h8000_0000;

endpackage

// File: rtl/lab1_imul_mac_acc.sv
// lab1_imul_mac_acc: accumulator register with a clear, an enable and the adder.
// Configuration macro LAB1_IMUL_MAC_SAT_EN:
//   defined   - signed two's-complement add that clamps to the max/min value
//               on overflow; the clamp is applied on every add.
//   undefined - modulo 2^p_nbits add. No saturation logic is built.
// Ports:
//   clk, reset - clock; synchronous active-high reset (acc <= 0)
//   clr        - load zero (has priority over en)
//   en         - load acc + addend
//   addend     - value added when en is high
//   acc        - current accumulator value
module lab1_imul_mac_acc
  import lab1_imul_mac_pkg::*;
#(
  parameter int p_nbits = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               en,
  input  logic [p_nbits-1:0] addend,
  output logic [p_nbits-1:0] acc
);

  logic [p_nbits-1:0] sum;

`ifdef LAB1_IMUL_MAC_SAT_EN
  localparam logic [p_nbits-1:0] sat_pos = {1'b0, {(p_nbits-1){1'b1}}};
  localparam logic [p_nbits-1:0] sat_neg = {1'b1, {(p_nbits-1){1'b0}}};

  logic [p_nbits-1:0] raw;
  logic               ovf;

  // Overflow happens only when both operands share a sign and the result's
  // sign differs; the operand sign then selects the clamp direction.
  always_comb begin
    raw = acc + addend;
    ovf = (acc[p_nbits-1] == addend[p_nbits-1]) &&
          (raw[p_nbits-1] != acc[p_nbits-1]);
    sum = raw;
    if (ovf) sum = acc[p_nbits-1] ? sat_neg : sat_pos;
  end
`else
  always_comb sum = acc + addend;
`endif

  always_ff @(posedge clk) begin
    if (reset)    acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= sum;
  end

endmodule

// File: rtl/lab1_imul_mac_client.sv
// lab1_imul_mac_client: multiply-accumulate client on the initiator side of
// the lab1 integer-multiplier val/rdy interface. A command gives a term count
// N; N operand pairs are passed through to the multiplier one at a time (at
// most one outstanding); the products are summed and the sum is returned.
// Configuration macro LAB1_IMUL_MAC_SAT_EN selects a saturating signed add
// (see lab1_imul_mac_acc).
// Ports:
//   clk, reset                 - clock; synchronous active-high reset
//   cmd_val/cmd_rdy/cmd_msg    - term count N (0 is legal)
//   opd_val/opd_rdy/opd_msg    - operand pair {a, b}
//   mreq_val/mreq_rdy/mreq_msg - multiply request {a, b} to the multiplier
//   mresp_val/mresp_rdy/mresp_msg - low p_nbits of the product
//   res_val/res_rdy/res_msg    - accumulated sum
module lab1_imul_mac_client
  import lab1_imul_mac_pkg::*;
#(
  parameter int p_nbits     = 32,
  parameter int p_cnt_nbits = 8
) (
  input  logic                   clk,
  input  logic                   reset,

  input  logic                   cmd_val,
  output logic                   cmd_rdy,
  input  logic [p_cnt_nbits-1:0] cmd_msg,

  input  logic                   opd_val,
  output logic                   opd_rdy,
  input  logic [2*p_nbits-1:0]   opd_msg,

  output logic                   mreq_val,
  input  logic                   mreq_rdy,
  output logic [2*p_nbits-1:0]   mreq_msg,

  input  logic                   mresp_val,
  output logic                   mresp_rdy,
  input  logic [p_nbits-1:0]     mresp_msg,

  output logic                   res_val,
  input  logic                   res_rdy,
  output logic [p_nbits-1:0]     res_msg
);

  state_t                 state, state_nxt;
  logic [p_cnt_nbits-1:0] remaining;
  logic                   cmd_go, opd_go, mresp_go, res_go;

  // Every val/rdy output is gated with reset so nothing is acknowledged
  // while the state register is still being initialised.
  always_comb begin
    cmd_rdy   = !reset && (state == IDLE);
    mreq_val  = !reset && (state == ISSUE) && opd_val;
    opd_rdy   = !reset && (state == ISSUE) && mreq_rdy;
    mresp_rdy = !reset && (state == WAIT);
    res_val   = !reset && (state == DONE);
    mreq_msg  = opd_msg;
  end

  assign cmd_go   = cmd_val   && cmd_rdy;
  assign opd_go   = opd_val   && opd_rdy;   // same cycle as the mreq handshake
  assign mresp_go = mresp_val && mresp_rdy;
  assign res_go   = res_val   && res_rdy;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (cmd_go)   state_nxt = (cmd_msg == '0) ? DONE : ISSUE;
      ISSUE: if (opd_go)   state_nxt = WAIT;
      WAIT:  if (mresp_go) state_nxt = (remaining == p_cnt_nbits'(1)) ? DONE : ISSUE;
      DONE:  if (res_go)   state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
    end else begin
      state <= state_nxt;
      if (cmd_go)        remaining <= cmd_msg;
      else if (mresp_go) remaining <= remaining - p_cnt_nbits'(1);
    end
  end

  lab1_imul_mac_acc #(.p_nbits(p_nbits)) u_acc (
    .clk    (clk),
    .reset  (reset),
    .clr    (cmd_go),
    .en     (mresp_go),
    .addend (mresp_msg),
    .acc    (res_msg)
  );

endmodule

// File: tb/tb_lab1_imul_mac_client.sv
// tb_lab1_imul_mac_client: directed-vector bench for lab1_imul_mac_client.
// Inputs change 1 time unit after the rising edge; outputs are checked
// before the next rising edge. Expected values are hand-computed constants.
module tb_lab1_imul_mac_client;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_val;
  logic        cmd_rdy;
  logic [7:0]  cmd_msg;
  logic        opd_val;
  logic        opd_rdy;
  logic [63:0] opd_msg;
  logic        mreq_val;
  logic        mreq_rdy;
  logic [63:0] mreq_msg;
  logic        mresp_val;
  logic        mresp_rdy;
  logic [31:0] mresp_msg;
  logic        res_val;
  logic        res_rdy;
  logic [31:0] res_msg;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  lab1_imul_mac_client dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_val   (cmd_val),
    .cmd_rdy   (cmd_rdy),
    .cmd_msg   (cmd_msg),
    .opd_val   (opd_val),
    .opd_rdy   (opd_rdy),
    .opd_msg   (opd_msg),
    .mreq_val  (mreq_val),
    .mreq_rdy  (mreq_rdy),
    .mreq_msg  (mreq_msg),
    .mresp_val (mresp_val),
    .mresp_rdy (mresp_rdy),
    .mresp_msg (mresp_msg),
    .res_val   (res_val),
    .res_rdy   (res_rdy),
    .res_msg   (res_msg)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Command handshake; leaves the DUT one cycle past it.
  task automatic start(input logic [7:0] n);
    cmd_val = 1'b1;
    cmd_msg = n;
    #1;
    chk("cmd_rdy_idle", cmd_rdy, 1);
    tick();
    cmd_val = 1'b0;
  endtask

  // One term with `lat` idle cycles in WAIT before the response arrives.
  task automatic term(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] resp, input int lat);
    opd_val  = 1'b1;
    opd_msg  = {a, b};
    mreq_rdy = 1'b1;
    #1;
    chk("mreq_val", mreq_val, 1);
    chk("mreq_msg", mreq_msg, {a, b});
    chk("opd_rdy", opd_rdy, 1);
    chk("cmd_rdy_busy", cmd_rdy, 0);
    tick();
    opd_val  = 1'b0;
    mreq_rdy = 1'b0;
    for (int i = 0; i < lat; i++) begin
      #1;
      chk("mresp_rdy_wait", mresp_rdy, 1);
      chk("opd_rdy_wait", opd_rdy, 0);
      tick();
    end
    mresp_val = 1'b1;
    mresp_msg = resp;
    #1;
    chk("mresp_rdy", mresp_rdy, 1);
    tick();
    mresp_val = 1'b0;
  endtask

  // Result check and handshake; cmd_rdy must return the following cycle.
  task automatic finish(input logic [31:0] exp);
    #1;
    chk("res_val", res_val, 1);
    chk("res_msg", res_msg, exp);
    res_rdy = 1'b1;
    tick();
    res_rdy = 1'b0;
    #1;
    chk("res_val_after", res_val, 0);
    chk("cmd_rdy_after", cmd_rdy, 1);
  endtask

  initial begin
    reset = 1'b1; cmd_val = 1'b0; cmd_msg = '0; opd_val = 1'b0; opd_msg = '0;
    mreq_rdy = 1'b0; mresp_val = 1'b0; mresp_msg = '0; res_rdy = 1'b0;

    // Reset: all val/rdy low while reset is held.
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_cmd_rdy", cmd_rdy, 0);
      chk("rst_opd_rdy", opd_rdy, 0);
      chk("rst_mreq_val", mreq_val, 0);
      chk("rst_mresp_rdy", mresp_rdy, 0);
      chk("rst_res_val", res_val, 0);
    end
    reset = 1'b0;
    #1;
    chk("post_rst_cmd_rdy", cmd_rdy, 1);
    chk("post_rst_res_val", res_val, 0);

    // Single term 3*4.
    start(8'd1);
    term(32'd3, 32'd4, 32'h0000_000C, 0);
    finish(32'h0000_000C);

    // Multi-term with wrap: 0x0A + 0xFFFFFFFE + 0x31 = 0x39.
    start(8'd3);
    term(32'd2, 32'd5, 32'h0000_000A, 1);
    term(32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 2);
    term(32'd7, 32'd7, 32'h0000_0031, 0);
    finish(32'h0000_0039);

    // Zero terms: result the cycle after cmd, operands ignored.
    start(8'd0);
    opd_val  = 1'b1;
    mreq_rdy = 1'b1;
    #1;
    chk("zero_mreq_val", mreq_val, 0);
    chk("zero_opd_rdy", opd_rdy, 0);
    opd_val  = 1'b0;
    mreq_rdy = 1'b0;
    finish(32'h0000_0000);

    // Backpressure on mreq_rdy, then on res_rdy.
    start(8'd1);
    opd_val = 1'b1;
    opd_msg = {32'd6, 32'd9};
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_opd_rdy", opd_rdy, 0);
      chk("bp_mreq_val", mreq_val, 1);
      chk("bp_mreq_msg", mreq_msg, {32'd6, 32'd9});
      tick();
    end
    term(32'd6, 32'd9, 32'h0000_0036, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_res_val", res_val, 1);
      chk("bp_res_msg", res_msg, 32'h0000_0036);
      tick();
    end
    finish(32'h0000_0036);

    // Reset while in WAIT abandons the command.
    start(8'd2);
    opd_val  = 1'b1;
    opd_msg  = {32'd1, 32'd1};
    mreq_rdy = 1'b1;
    tick();
    opd_val  = 1'b0;
    mreq_rdy = 1'b0;
    #1;
    chk("wait_mresp_rdy", mresp_rdy, 1);
    reset = 1'b1;
    #1;
    chk("wait_rst_mresp_rdy", mresp_rdy, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("abort_cmd_rdy", cmd_rdy, 1);
    chk("abort_res_val", res_val, 0);
    chk("abort_mresp_rdy", mresp_rdy, 0);

    // Saturation: 0x40000000 + 0x40000000.
    start(8'd2);
    term(32'h0000_8000, 32'h0000_8000, 32'h4000_0000, 0);
    term(32'h0000_8000, 32'h0000_8000, 32'h4000_0000, 0);
`ifdef LAB1_IMUL_MAC_SAT_EN
    finish(32'h7FFF_FFFF);
`else
    finish(32'h8000_0000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
